pi_cart_bus_bridge: RTL and testbench
=====================================

Name: pi_cart_bus_bridge

Overview:
- Bridges the N64 parallel-interface (PI) cartridge bus to the 32 MB SDRAM controller's read and write ports.
- Synchronises the asynchronous PI strobes, latches the two-phase multiplexed address and decodes the ROM window.
- Issues one 4-phase SDRAM request at a time, drives read data onto AD and auto-increments the address per halfword.
- Sits directly upstream of the SDRAM controller.

Parameters:
- SYNC_STAGES, 2, flop depth of the PI input synchronisers (strobes and AD pipelined identically).
- ROM_BASE, 32'h1000_0000, PI byte address mapped to SDRAM byte 0.
- ROM_SIZE, 32'h0200_0000, window size in bytes; power of two.

Ports:
- clk  in  1  system clock; same clock as the SDRAM controller.
- rst  in  1  reset; asynchronous, active-high.
- pi_ad_in  in  16  PI AD bus, input side.
- pi_ad_out  out  16  PI AD bus, output side.
- pi_ad_oe  out  1  AD output enable; top level tristates AD.
- pi_ale_h  in  1  PI address latch enable, high.
- pi_ale_l  in  1  PI address latch enable, low.
- pi_read_n  in  1  PI read strobe, active-low.
- pi_write_n  in  1  PI write strobe, active-low.
- readport_rd  out  1  SDRAM read request.
- readport_addr  out  32  SDRAM byte address; bit0 always 0.
- readport_data  in  16  SDRAM read data; valid when readport_ack=1.
- readport_ack  in  1  SDRAM read acknowledge.
- writeport_wr  out  1  SDRAM write request.
- writeport_addr  out  32  SDRAM byte address; bit0 always 0.
- writeport_data  out  16  SDRAM write data.
- writeport_ack  in  1  SDRAM write acknowledge.
- underrun_count  out  16  saturating count of reads served without valid data.

Behaviour:
- Reset values: all outputs 0; all state IDLE; buffers invalid; sync chains 1 for strobes and ALE 0.
- Strobes and AD pass through SYNC_STAGES flops. Edge detection uses the synchronised value vs its 1-cycle delay.
- Address capture, high half: rising edge of ale_l while ale_h=1 -> addr_hi <= AD.
- Address capture, low half: falling edge of ale_l while ale_h=0 -> addr_lo <= AD. Then:
  - hit <= ((addr & ~(ROM_SIZE-1)) == ROM_BASE);
  - ptr <= addr & (ROM_SIZE-1) & ~1;
  - buffers invalidated.
- On hit, a fetch is launched at ptr. On miss, no SDRAM traffic and pi_ad_oe stays 0.
- ptr increment is +2, masked by ROM_SIZE-1, so it wraps to 0 at the window end.
- Request FSM states: IDLE, RD_REQ, RD_REL, WR_REQ, WR_REL.
  - RD_REQ: rd=1 until ack=1; on ack, capture readport_data into buffer, mark valid, rd=0, go to RD_REL.
  - RD_REL: wait ack=0, then IDLE.
  - WR_REQ / WR_REL: identical sequencing on the write port.
- Exactly one request is outstanding at any time. Request address and data are held stable from request assertion until ack.
- Read cycle:
  - pi_ad_oe = hit & ~read_n_sync.
  - pi_ad_out = buffer while valid. If the buffer is invalid at the read_n falling edge: output 16'h0000 and underrun_count += 1 (saturates at FFFF).
  - On read_n rising edge: ptr += 2, buffer invalidated, next fetch queued.
- Write cycle: on write_n rising edge with hit, latch AD and ptr into a write slot, queue a write, ptr += 2. A write queued while idle wins over a queued fetch.
- New address latched mid-request: the handshake always completes (never aborted). Returned read data is discarded if its address tag no longer matches; pending queued ops are cleared.
- Write slot already full when a new write edge arrives: the new write is dropped and counted in underrun_count.
- Reset asserted mid-handshake: all outputs return to 0 immediately (asynchronous).

Optional Feature:
- Macro: PI_PREFETCH_EN.
- Defined: two-entry FIFO of (tag, data). After each fill, the next ptr+2 is fetched if a slot is free. A read_n rising edge pops the head.
- Undefined: single buffer; the fetch is issued only after the address latch or the read_n rising edge.

Test Plan:
- Read hit: latch 0x1000_0100, one read -> readport_addr=0x100; AD shows SDRAM data 0xBEEF while read_n=0; next request addr=0x102.
- Miss: latch 0x0800_0000, pulse read_n -> pi_ad_oe stays 0 and readport_rd never asserts.
- Wrap: latch 0x11FF_FFFE, two reads -> second request addr=0x0000_0000.
- Underrun: ack delayed 40 cycles, read_n falls 5 cycles after latch -> AD=0x0000, underrun_count=1. Back-to-back with PI_PREFETCH_EN -> count stays 0.
- Write: latch 0x1000_0010, write_n pulse with AD=0x1234 -> writeport_wr, addr=0x10, data=0x1234 held until ack; then wr=0 and ack low observed.
- Re-latch mid-fetch: new address during RD_REQ -> handshake completes, stale data not driven, fetch issued at the new address.

Source files
------------

// File: rtl/pi_cart_bus_bridge_if.sv
// Bus bundle between the N64 PI cartridge pins, the bridge and the SDRAM controller ports.
// The bridge uses the master modport; the pad ring / SDRAM side uses the slave modport.
interface pi_cart_bus_bridge_if;
    logic [15:0] pi_ad_in;
    logic [15:0] pi_ad_out;
    logic        pi_ad_oe;
    logic        pi_ale_h;
    logic        pi_ale_l;
    logic        pi_read_n;
    logic        pi_write_n;

    logic        readport_rd;
    logic [31:0] readport_addr;
    logic [15:0] readport_data;
    logic        readport_ack;

    logic        writeport_wr;
    logic [31:0] writeport_addr;
    logic [15:0] writeport_data;
    logic        writeport_ack;

    modport master (
        input  pi_ad_in, pi_ale_h, pi_ale_l, pi_read_n, pi_write_n,
        input  readport_data, readport_ack, writeport_ack,
        output pi_ad_out, pi_ad_oe,
        output readport_rd, readport_addr,
        output writeport_wr, writeport_addr, writeport_data
    );

    modport slave (
        output pi_ad_in, pi_ale_h, pi_ale_l, pi_read_n, pi_write_n,
        output readport_data, readport_ack, writeport_ack,
        input  pi_ad_out, pi_ad_oe,
        input  readport_rd, readport_addr,
        input  writeport_wr, writeport_addr, writeport_data
    );
endinterface

// File: rtl/pi_cart_bus_bridge.sv
// N64 PI cartridge bus to SDRAM read/write port bridge with one outstanding 4-phase request.
// Define PI_PREFETCH_EN for a two-entry read-ahead FIFO; otherwise a single read buffer is used.
module pi_cart_bus_bridge #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] ROM_BASE    = 32'h1000_0000,
    parameter logic [31:0] ROM_SIZE    = 32'h0200_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    pi_cart_bus_bridge_if.master  bus,
    output logic [15:0]           underrun_count
);
    localparam logic [31:0] WIN_MASK = ROM_SIZE - 32'd1;
    localparam logic [31:0] PTR_MASK = WIN_MASK & ~32'd1;

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_REL, WR_REQ, WR_REL} state_t;

    logic [SYNC_STAGES-1:0] read_n_sr, write_n_sr, ale_h_sr, ale_l_sr;
    logic [15:0]            ad_sr [SYNC_STAGES];
    logic                   read_n_d, write_n_d, ale_l_d;
    logic                   read_n_s, write_n_s, ale_h_s, ale_l_s;
    logic [15:0]            ad_s;

    state_t      state;
    logic [15:0] addr_hi;
    logic [31:0] ptr;
    logic        hit;
    logic        rd_stale;
    logic        rd_under;
    logic        wslot_full;
    logic [31:0] wslot_addr;
    logic [15:0] wslot_data;

`ifdef PI_PREFETCH_EN
    logic [15:0] fifo_data [2];
    logic [31:0] fifo_tag  [2];
    logic        fifo_head;
    logic [1:0]  fifo_count;
    logic [31:0] next_fetch;
    logic        pop;
    logic [31:0] resync_ptr;
`else
    logic [15:0] buf_data;
    logic        buf_valid;
    logic        fetch_pending;
`endif

    logic [31:0] lat_addr, lat_ptr, ptr_inc, fetch_addr;
    logic        lat_hit, hi_cap, lat_lo;
    logic        read_fall, read_rise, write_rise;
    logic        adv_rd, adv_wr, drop_wr, resync, push, data_valid, fetch_go, under_now;
    logic [15:0] head_data;
    logic [1:0]  under_inc;
    logic [16:0] under_sum;

    // Strobes, ALE and AD share one pipeline depth so they stay mutually aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_n_sr  <= '1;
            write_n_sr <= '1;
            ale_h_sr   <= '0;
            ale_l_sr   <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) ad_sr[i] <= '0;
            read_n_d   <= 1'b1;
            write_n_d  <= 1'b1;
            ale_l_d    <= 1'b0;
        end else begin
            read_n_sr[0]  <= bus.pi_read_n;
            write_n_sr[0] <= bus.pi_write_n;
            ale_h_sr[0]   <= bus.pi_ale_h;
            ale_l_sr[0]   <= bus.pi_ale_l;
            ad_sr[0]      <= bus.pi_ad_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                read_n_sr[i]  <= read_n_sr[i-1];
                write_n_sr[i] <= write_n_sr[i-1];
                ale_h_sr[i]   <= ale_h_sr[i-1];
                ale_l_sr[i]   <= ale_l_sr[i-1];
                ad_sr[i]      <= ad_sr[i-1];
            end
            read_n_d  <= read_n_s;
            write_n_d <= write_n_s;
            ale_l_d   <= ale_l_s;
        end
    end

    assign read_n_s  = read_n_sr[SYNC_STAGES-1];
    assign write_n_s = write_n_sr[SYNC_STAGES-1];
    assign ale_h_s   = ale_h_sr[SYNC_STAGES-1];
    assign ale_l_s   = ale_l_sr[SYNC_STAGES-1];
    assign ad_s      = ad_sr[SYNC_STAGES-1];

    assign lat_addr   = {addr_hi, ad_s};
    assign lat_hit    = (lat_addr & ~WIN_MASK) == ROM_BASE;
    assign lat_ptr    = lat_addr & PTR_MASK;
    assign ptr_inc    = (ptr + 32'd2) & PTR_MASK;
    assign hi_cap     = ale_l_s & ~ale_l_d & ale_h_s;
    assign lat_lo     = ~ale_l_s & ale_l_d & ~ale_h_s;
    assign read_fall  = ~read_n_s & read_n_d;
    assign read_rise  = read_n_s & ~read_n_d;
    assign write_rise = write_n_s & ~write_n_d;
    assign adv_rd     = read_rise & hit;
    assign adv_wr     = write_rise & hit & ~wslot_full;
    assign drop_wr    = write_rise & hit & wslot_full;
    // Data returned for a request that was overtaken by an address change is never buffered.
    assign push       = (state == RD_REQ) & bus.readport_ack & ~rd_stale;

`ifdef PI_PREFETCH_EN
    assign data_valid = (fifo_count != 2'd0) && (fifo_tag[fifo_head] == ptr);
    assign head_data  = fifo_data[fifo_head];
    assign pop        = adv_rd & data_valid;
    assign resync     = lat_lo | (adv_rd & ~data_valid) | adv_wr;
    assign resync_ptr = lat_lo ? lat_ptr : ptr_inc;
    assign fetch_go   = hit & ~fifo_count[1];
    assign fetch_addr = next_fetch;
`else
    assign data_valid = buf_valid;
    assign head_data  = buf_data;
    assign resync     = lat_lo | adv_rd | adv_wr;
    assign fetch_go   = fetch_pending & hit;
    assign fetch_addr = ptr;
`endif

    assign under_now = read_fall ? ~data_valid : rd_under;
    assign under_inc = {1'b0, read_fall & hit & ~data_valid} + {1'b0, drop_wr};
    assign under_sum = {1'b0, underrun_count} + {15'b0, under_inc};

    // Request FSM plus address pointer, read buffering and write slot; later assignments take priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            addr_hi             <= '0;
            ptr                 <= '0;
            hit                 <= 1'b0;
            rd_stale            <= 1'b0;
            rd_under            <= 1'b0;
            wslot_full          <= 1'b0;
            wslot_addr          <= '0;
            wslot_data          <= '0;
            underrun_count      <= '0;
            bus.pi_ad_out       <= '0;
            bus.pi_ad_oe        <= 1'b0;
            bus.readport_rd     <= 1'b0;
            bus.readport_addr   <= '0;
            bus.writeport_wr    <= 1'b0;
            bus.writeport_addr  <= '0;
            bus.writeport_data  <= '0;
`ifdef PI_PREFETCH_EN
            for (int i = 0; i < 2; i++) begin
                fifo_data[i] <= '0;
                fifo_tag[i]  <= '0;
            end
            fifo_head  <= 1'b0;
            fifo_count <= '0;
            next_fetch <= '0;
`else
            buf_data      <= '0;
            buf_valid     <= 1'b0;
            fetch_pending <= 1'b0;
`endif
        end else begin
            underrun_count <= under_sum[16] ? 16'hFFFF : under_sum[15:0];
            if (hi_cap) addr_hi <= ad_s;
            if (lat_lo) hit <= lat_hit;
            if (read_fall) rd_under <= ~data_valid;

            bus.pi_ad_oe  <= hit & ~read_n_s;
            bus.pi_ad_out <= (hit & ~read_n_s & ~under_now & data_valid) ? head_data : 16'h0000;

            if (adv_wr) begin
                wslot_full <= 1'b1;
                wslot_addr <= ptr;
                wslot_data <= ad_s;
            end

            case (state)
                IDLE: begin
                    if (wslot_full) begin
                        bus.writeport_wr   <= 1'b1;
                        bus.writeport_addr <= wslot_addr;
                        bus.writeport_data <= wslot_data;
                        wslot_full         <= 1'b0;
                        state              <= WR_REQ;
                    end else if (fetch_go) begin
                        bus.readport_rd   <= 1'b1;
                        bus.readport_addr <= fetch_addr;
                        rd_stale          <= 1'b0;
                        state             <= RD_REQ;
`ifdef PI_PREFETCH_EN
                        next_fetch <= (next_fetch + 32'd2) & PTR_MASK;
`else
                        fetch_pending <= 1'b0;
`endif
                    end
                end
                RD_REQ: if (bus.readport_ack) begin
                    bus.readport_rd <= 1'b0;
                    state           <= RD_REL;
                end
                RD_REL: if (!bus.readport_ack) state <= IDLE;
                WR_REQ: if (bus.writeport_ack) begin
                    bus.writeport_wr <= 1'b0;
                    state            <= WR_REL;
                end
                WR_REL: if (!bus.writeport_ack) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (lat_lo) wslot_full <= 1'b0;
            if (resync) rd_stale <= 1'b1;

            if (lat_lo) ptr <= lat_ptr;
            else if (adv_rd | adv_wr) ptr <= ptr_inc;

`ifdef PI_PREFETCH_EN
            if (push) begin
                fifo_data[fifo_head ^ fifo_count[0]] <= bus.readport_data;
                fifo_tag[fifo_head ^ fifo_count[0]]  <= bus.readport_addr;
            end
            if (resync) begin
                fifo_count <= '0;
                next_fetch <= resync_ptr;
            end else begin
                fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
                if (pop) fifo_head <= ~fifo_head;
            end
`else
            if (resync) buf_valid <= 1'b0;
            else if (push) begin
                buf_valid <= 1'b1;
                buf_data  <= bus.readport_data;
            end
            if (lat_lo) fetch_pending <= lat_hit;
            else if (adv_rd) fetch_pending <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_pi_cart_bus_bridge.sv
// Directed-plus-random bench for pi_cart_bus_bridge: PI bus driver, SDRAM port responders
// and a window/memory reference model computed with plain address arithmetic.
module tb_pi_cart_bus_bridge;
    localparam logic [31:0] ROM_BASE = 32'h1000_0000;
    localparam logic [31:0] ROM_SIZE = 32'h0200_0000;

    typedef enum {OP_LATCH, OP_READ_LOW, OP_READ_HIGH, OP_WRITE} op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] underrun_count;

    pi_cart_bus_bridge_if bus();

    pi_cart_bus_bridge #(
        .SYNC_STAGES(2),
        .ROM_BASE   (ROM_BASE),
        .ROM_SIZE   (ROM_SIZE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .underrun_count (underrun_count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          ack_delay = 2;
    int          rd_hold_err = 0;
    int          wr_hold_err = 0;
    logic [15:0] mem [int unsigned];
    logic [31:0] rd_log [$];
    logic [31:0] wr_log_addr [$];
    logic [15:0] wr_log_data [$];

    function automatic logic [15:0] memRead(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = 16'($urandom);
        return mem[a];
    endfunction

    function automatic bit inWindow(input logic [31:0] pi_addr);
        return (pi_addr >= ROM_BASE) && (pi_addr < ROM_BASE + ROM_SIZE);
    endfunction

    function automatic logic [31:0] winOffset(input logic [31:0] pi_addr);
        return ((pi_addr - ROM_BASE) % ROM_SIZE) & ~32'd1;
    endfunction

    function automatic logic [31:0] nextOffset(input logic [31:0] off);
        return (off + 32'd2) % ROM_SIZE;
    endfunction

    function automatic logic [31:0] logAt(input int idx);
        if (idx < rd_log.size()) return rd_log[idx];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input op_t op, input logic [31:0] value, input int settle);
        case (op)
            OP_LATCH: begin
                bus.pi_ale_h = 1'b1;
                bus.pi_ad_in = value[31:16];
                waitCycles(3);
                bus.pi_ale_l = 1'b1;
                waitCycles(3);
                bus.pi_ale_h = 1'b0;
                bus.pi_ad_in = value[15:0];
                waitCycles(3);
                bus.pi_ale_l = 1'b0;
            end
            OP_READ_LOW:  bus.pi_read_n = 1'b0;
            OP_READ_HIGH: bus.pi_read_n = 1'b1;
            OP_WRITE: begin
                bus.pi_ad_in = value[15:0];
                waitCycles(2);
                bus.pi_write_n = 1'b0;
                waitCycles(6);
                bus.pi_write_n = 1'b1;
            end
            default: ;
        endcase
        waitCycles(settle);
    endtask

    // SDRAM read port: logs each request, checks its address is held, answers after ack_delay.
    initial begin
        logic [31:0] a;
        bit          dropped;
        bus.readport_ack  = 1'b0;
        bus.readport_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (bus.readport_rd === 1'b1) begin
                a = bus.readport_addr;
                rd_log.push_back(a);
                for (int k = 0; k < ack_delay; k++) begin
                    @(negedge clk);
                    if (bus.readport_addr !== a || bus.readport_rd !== 1'b1) rd_hold_err++;
                end
                bus.readport_data = memRead(a);
                bus.readport_ack  = 1'b1;
                dropped = 1'b0;
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (bus.readport_rd === 1'b0) begin
                        dropped = 1'b1;
                        break;
                    end
                end
                if (!dropped) rd_hold_err++;
                bus.readport_ack  = 1'b0;
                bus.readport_data = 16'($urandom);
            end
        end
    end

    // SDRAM write port: checks address/data are held until ack, then commits to the memory model.
    initial begin
        logic [31:0] a;
        logic [15:0] d;
        bit          dropped;
        bus.writeport_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.writeport_wr === 1'b1) begin
                a = bus.writeport_addr;
                d = bus.writeport_data;
                for (int k = 0; k < ack_delay; k++) begin
                    @(negedge clk);
                    if (bus.writeport_addr !== a || bus.writeport_data !== d || bus.writeport_wr !== 1'b1)
                        wr_hold_err++;
                end
                mem[a] = d;
                wr_log_addr.push_back(a);
                wr_log_data.push_back(d);
                bus.writeport_ack = 1'b1;
                dropped = 1'b0;
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (bus.writeport_wr === 1'b0) begin
                        dropped = 1'b1;
                        break;
                    end
                end
                if (!dropped) wr_hold_err++;
                bus.writeport_ack = 1'b0;
            end
        end
    end

    initial begin
        logic [31:0] pi_addr, off;
        logic [15:0] exp0, exp1, wdata;
        bit          seen;

        rst            = 1'b1;
        bus.pi_ad_in   = 16'h0000;
        bus.pi_ale_h   = 1'b0;
        bus.pi_ale_l   = 1'b0;
        bus.pi_read_n  = 1'b1;
        bus.pi_write_n = 1'b1;
        waitCycles(3);
        checkOutput("reset_rd",       {31'b0, bus.readport_rd},  32'd0);
        checkOutput("reset_wr",       {31'b0, bus.writeport_wr}, 32'd0);
        checkOutput("reset_oe",       {31'b0, bus.pi_ad_oe},     32'd0);
        checkOutput("reset_ad_out",   {16'b0, bus.pi_ad_out},    32'd0);
        checkOutput("reset_rd_addr",  bus.readport_addr,         32'd0);
        checkOutput("reset_underrun", {16'b0, underrun_count},   32'd0);
        rst = 1'b0;
        waitCycles(5);
        checkOutput("idle_rd", {31'b0, bus.readport_rd}, 32'd0);

        // Directed read hit
        mem[32'h100] = 16'hBEEF;
        rd_log.delete();
        applyStimulus(OP_LATCH, 32'h1000_0100, 20);
        checkOutput("hit_req_addr", logAt(0), 32'h100);
        applyStimulus(OP_READ_LOW, 32'd0, 8);
        checkOutput("hit_oe", {31'b0, bus.pi_ad_oe}, 32'd1);
        checkOutput("hit_ad", {16'b0, bus.pi_ad_out}, 32'h0000_BEEF);
        applyStimulus(OP_READ_HIGH, 32'd0, 20);
        checkOutput("hit_next_addr", logAt(1), 32'h102);
        checkOutput("hit_oe_released", {31'b0, bus.pi_ad_oe}, 32'd0);

        // Random hits, two sequential halfwords each
        for (int it = 0; it < 5; it++) begin
            off     = 32'($urandom_range(0, int'(ROM_SIZE / 2) - 1)) * 32'd2;
            pi_addr = ROM_BASE + off + 32'($urandom_range(0, 1));
            exp0    = memRead(winOffset(pi_addr));
            exp1    = memRead(nextOffset(winOffset(pi_addr)));
            rd_log.delete();
            applyStimulus(OP_LATCH, pi_addr, 20);
            applyStimulus(OP_READ_LOW, 32'd0, 8);
            checkOutput("rand_ad0", {16'b0, bus.pi_ad_out}, {16'b0, exp0});
            applyStimulus(OP_READ_HIGH, 32'd0, 20);
            applyStimulus(OP_READ_LOW, 32'd0, 8);
            checkOutput("rand_ad1", {16'b0, bus.pi_ad_out}, {16'b0, exp1});
            applyStimulus(OP_READ_HIGH, 32'd0, 20);
            checkOutput("rand_addr0", logAt(0), winOffset(pi_addr));
            checkOutput("rand_addr1", logAt(1), nextOffset(winOffset(pi_addr)));
        end

        // Misses: no SDRAM traffic, AD never enabled
        for (int it = 0; it < 3; it++) begin
            pi_addr = (it == 0) ? 32'h0800_0000 : 32'($urandom);
            if (inWindow(pi_addr)) pi_addr = pi_addr ^ 32'h8000_0000;
            rd_log.delete();
            applyStimulus(OP_LATCH, pi_addr, 10);
            applyStimulus(OP_READ_LOW, 32'd0, 8);
            checkOutput("miss_oe", {31'b0, bus.pi_ad_oe}, 32'd0);
            checkOutput("miss_ad", {16'b0, bus.pi_ad_out}, 32'd0);
            applyStimulus(OP_READ_HIGH, 32'd0, 10);
            checkOutput("miss_no_req", 32'(rd_log.size()), 32'd0);
        end

        // Window wrap
        rd_log.delete();
        exp1 = memRead(nextOffset(winOffset(32'h11FF_FFFE)));
        applyStimulus(OP_LATCH, 32'h11FF_FFFE, 20);
        applyStimulus(OP_READ_LOW, 32'd0, 8);
        applyStimulus(OP_READ_HIGH, 32'd0, 20);
        applyStimulus(OP_READ_LOW, 32'd0, 8);
        checkOutput("wrap_ad1", {16'b0, bus.pi_ad_out}, {16'b0, exp1});
        applyStimulus(OP_READ_HIGH, 32'd0, 20);
        checkOutput("wrap_addr0", logAt(0), 32'h01FF_FFFE);
        checkOutput("wrap_addr1", logAt(1), 32'h0000_0000);

        // Underrun: read strobe arrives long before the slow SDRAM answers
        ack_delay = 40;
        applyStimulus(OP_LATCH, 32'h1000_0200, 5);
        applyStimulus(OP_READ_LOW, 32'd0, 8);
        checkOutput("under_oe", {31'b0, bus.pi_ad_oe}, 32'd1);
        checkOutput("under_ad", {16'b0, bus.pi_ad_out}, 32'd0);
        checkOutput("under_count", {16'b0, underrun_count}, 32'd1);
        applyStimulus(OP_READ_HIGH, 32'd0, 150);
        ack_delay = 2;

        // Writes: directed value then a random one, each read back through the window
        ack_delay = 6;
        for (int it = 0; it < 2; it++) begin
            off   = (it == 0) ? 32'h10 : 32'($urandom_range(0, int'(ROM_SIZE / 2) - 1)) * 32'd2;
            wdata = (it == 0) ? 16'h1234 : 16'($urandom);
            wr_log_addr.delete();
            wr_log_data.delete();
            applyStimulus(OP_LATCH, ROM_BASE + off, 20);
            applyStimulus(OP_WRITE, {16'b0, wdata}, 30);
            checkOutput("wr_count", 32'(wr_log_addr.size()), 32'd1);
            checkOutput("wr_addr", (wr_log_addr.size() > 0) ? wr_log_addr[0] : 32'hxxxx_xxxx, off);
            checkOutput("wr_data", (wr_log_data.size() > 0) ? {16'b0, wr_log_data[0]} : 32'hxxxx_xxxx, {16'b0, wdata});
            checkOutput("wr_released", {31'b0, bus.writeport_wr}, 32'd0);
            applyStimulus(OP_LATCH, ROM_BASE + off, 30);
            applyStimulus(OP_READ_LOW, 32'd0, 8);
            checkOutput("wr_readback", {16'b0, bus.pi_ad_out}, {16'b0, wdata});
            applyStimulus(OP_READ_HIGH, 32'd0, 30);
        end
        checkOutput("wr_hold", 32'(wr_hold_err), 32'd0);
        ack_delay = 2;

        // Re-latch while the first fetch is still waiting for ack
        mem[32'h400] = 16'h1111;
        mem[32'h600] = 16'h2222;
        ack_delay = 30;
        rd_log.delete();
        applyStimulus(OP_LATCH, 32'h1000_0400, 4);
        applyStimulus(OP_LATCH, 32'h1000_0600, 80);
        applyStimulus(OP_READ_LOW, 32'd0, 8);
        checkOutput("relatch_ad", {16'b0, bus.pi_ad_out}, 32'h0000_2222);
        applyStimulus(OP_READ_HIGH, 32'd0, 80);
        checkOutput("relatch_addr0", logAt(0), 32'h400);
        checkOutput("relatch_addr1", logAt(1), 32'h600);
        ack_delay = 2;

        checkOutput("final_underrun", {16'b0, underrun_count}, 32'd1);
        checkOutput("rd_hold", 32'(rd_hold_err), 32'd0);

        // Asynchronous reset in the middle of a read handshake
        ack_delay = 60;
        applyStimulus(OP_LATCH, 32'h1000_0800, 0);
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.readport_rd === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("rst_mid_rd_seen", {31'b0, seen}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_rd",       {31'b0, bus.readport_rd}, 32'd0);
        checkOutput("rst_mid_addr",     bus.readport_addr,        32'd0);
        checkOutput("rst_mid_underrun", {16'b0, underrun_count},  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
